mkio_rx_frontend: RTL and testbench
===================================

MKIO_RX_FRONTEND -- requirements
Module: mkio_rx_frontend

Interface
REQ-001 SHALL provide parameter FILT_LEN, default 3: consecutive equal samples required before a filtered line changes (range 1..15).
REQ-002 SHALL provide parameter IDLE_TIMEOUT, default 128: clk cycles of no activity on the locked channel before the lock releases (range 2..1023).
REQ-003 SHALL have port clk  input  1  system clock (32 MHz; 32 cycles per MKIO bit).
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports DI1A, DI0A  input  1 each  raw channel A line-receiver outputs, asynchronous to clk.
REQ-006 SHALL have ports DI1B, DI0B  input  1 each  raw channel B line-receiver outputs, asynchronous to clk.
REQ-007 SHALL have port rx_enable  input  1  receive enable; low while the local transmitter is active.
REQ-008 SHALL have ports DI1, DI0  output  1 each  cleaned line pair of the selected channel, feeding the Manchester receiver.
REQ-009 SHALL have port chan_b  output  1  selected channel: 0 = A, 1 = B.
REQ-010 SHALL have port chan_active  output  1  high while a channel is locked.
REQ-011 SHALL have port line_error  output  1  one-cycle pulse on an invalid line state (both lines high) on the locked channel.
REQ-012 SHALL have port collision  output  1  one-cycle pulse, at most once per lock, on activity on the non-locked channel.

Function
REQ-013 SHALL double-flop synchronise each of the four raw inputs.
REQ-014 Each synchronised line SHALL feed a filter whose output takes a new level only after FILT_LEN consecutive samples at that level; latency from the first synchronised sample to the filtered change SHALL be FILT_LEN cycles.
REQ-015 A channel SHALL be "active" in a cycle when either of its filtered lines is 1.
REQ-016 The FSM SHALL have exactly three states: IDLE, LOCK_A, LOCK_B.
REQ-017 In IDLE, activity on A SHALL go to LOCK_A, and activity on B alone SHALL go to LOCK_B; when both are active in the same cycle, A SHALL win.
REQ-018 In LOCK_x, a 10-bit idle counter SHALL clear on any activity on channel x and otherwise increment; reaching IDLE_TIMEOUT-1 SHALL return the FSM to IDLE on the next edge.
REQ-019 In LOCK_x, DI1/DI0 SHALL be registered copies of channel x's filtered lines, giving a total latency of 2+FILT_LEN+1 cycles from the raw input to the output.
REQ-020 In IDLE, DI1 and DI0 SHALL be 0.
REQ-021 When both filtered lines of the locked channel are 1, DI1 and DI0 SHALL be forced to 0 and line_error SHALL pulse on the first such cycle only; it SHALL re-arm after the lines leave that state.
REQ-022 Activity on the non-locked channel SHALL pulse collision once per lock and SHALL NOT change the selection.
REQ-023 rx_enable=0 SHALL force the FSM to IDLE, zero DI1/DI0, and clear the idle counter in the next cycle; the filters SHALL keep running.
REQ-024 chan_b SHALL hold its last value in IDLE.
REQ-025 chan_active SHALL equal (state != IDLE).

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all synchroniser and filter registers, counters and outputs to 0, and set the FSM to IDLE.
REQ-027 Reset asserted mid-word SHALL abort the lock with no line_error or collision pulse; after release, a new lock SHALL require fresh filtered activity.

Configuration
REQ-028 With macro MKIO_RX_CHAN_B_EN defined, channel B SHALL be fully supported as specified above.
REQ-029 Without MKIO_RX_CHAN_B_EN, DI1B/DI0B SHALL be ignored (no B synchronisers or filters), LOCK_B SHALL be unreachable, chan_b SHALL be constant 0, and collision SHALL be constant 0.

Verification
REQ-030 Defaults, A sends 1-0-1 Manchester half-bits of 16 cycles each -> chan_active rises 6 cycles after the first raw edge; DI1/DI0 reproduce the waveform delayed by 6 cycles; chan_b=0.
REQ-031 A 2-cycle glitch on DI1B while idle -> no lock, DI1/DI0 stay 0.
REQ-032 DI1A and DI1B rise in the same cycle -> LOCK_A; collision pulses exactly once.
REQ-033 A active, then both lines of A high for 5 cycles -> one line_error pulse; DI1/DI0 read 0 for that span.
REQ-034 A goes silent -> chan_active falls 128 cycles after A's last filtered activity; a later B word locks with chan_b=1.
REQ-035 rx_enable dropped mid-word, then reset_n pulsed low mid-word -> each forces IDLE with outputs 0; built without MKIO_RX_CHAN_B_EN, B-only traffic -> no lock.

Source files
------------

// File: rtl/mkio_rx_frontend.sv
// MKIO receive front end: synchronise and filter both line pairs, lock onto one channel.
// Channel B is compiled in only when MKIO_RX_CHAN_B_EN is defined; the default build is A-only.
module mkio_rx_frontend #(
   parameter int unsigned FILT_LEN     = 3,
   parameter int unsigned IDLE_TIMEOUT = 128
) (
   input  logic clk,
   input  logic reset_n,
   input  logic DI1A,
   input  logic DI0A,
   input  logic DI1B,
   input  logic DI0B,
   input  logic rx_enable,
   output logic DI1,
   output logic DI0,
   output logic chan_b,
   output logic chan_active,
   output logic line_error,
   output logic collision
);

`ifdef MKIO_RX_CHAN_B_EN
   localparam int unsigned NumLines = 4;
   logic [NumLines-1:0] raw;
   assign raw = {DI0B, DI1B, DI0A, DI1A};
`else
   localparam int unsigned NumLines = 2;
   logic [NumLines-1:0] raw;
   logic                unused_b;
   assign raw      = {DI0A, DI1A};
   assign unused_b = DI1B ^ DI0B;
`endif

   typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_e;

   logic [NumLines-1:0] sync1_q, sync2_q, filt_q;
   logic [3:0]          flt_cnt_q [NumLines];
   logic                fa1, fa0, fb1, fb0, act_a, act_b;
   logic                sel1, sel0, both, own_act, other_act;
   logic [9:0]          idle_cnt_q;
   logic                err_seen_q, coll_done_q;
   state_e              state_q, state_d;

   // Filter counter tracks consecutive samples that disagree with the current filtered level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
         for (int i = 0; i < NumLines; i++) flt_cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < NumLines; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               flt_cnt_q[i] <= '0;
            end else if (flt_cnt_q[i] == 4'(FILT_LEN - 1)) begin
               filt_q[i]    <= sync2_q[i];
               flt_cnt_q[i] <= '0;
            end else begin
               flt_cnt_q[i] <= flt_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   assign fa1 = filt_q[0];
   assign fa0 = filt_q[1];
`ifdef MKIO_RX_CHAN_B_EN
   assign fb1 = filt_q[2];
   assign fb0 = filt_q[3];
`else
   assign fb1 = 1'b0;
   assign fb0 = 1'b0;
`endif
   assign act_a = fa1 | fa0;
   assign act_b = fb1 | fb0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (act_a) state_d = StLockA;
`ifdef MKIO_RX_CHAN_B_EN
            else if (act_b) state_d = StLockB;
`endif
         end
         StLockA: if (!act_a && idle_cnt_q == 10'(IDLE_TIMEOUT - 1)) state_d = StIdle;
         StLockB: if (!act_b && idle_cnt_q == 10'(IDLE_TIMEOUT - 1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (!rx_enable) state_d = StIdle;
   end

   // Outputs are registered from the channel selected by the next state.
   always_comb begin
      sel1      = 1'b0;
      sel0      = 1'b0;
      own_act   = 1'b0;
      other_act = 1'b0;
      case (state_d)
         StLockA: begin
            sel1    = fa1;
            sel0    = fa0;
            own_act = act_a;
`ifdef MKIO_RX_CHAN_B_EN
            other_act = act_b;
`endif
         end
         StLockB: begin
            sel1    = fb1;
            sel0    = fb0;
            own_act = act_b;
`ifdef MKIO_RX_CHAN_B_EN
            other_act = act_a;
`endif
         end
         default: ;
      endcase
      both = sel1 & sel0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         idle_cnt_q  <= '0;
         DI1         <= 1'b0;
         DI0         <= 1'b0;
         chan_b      <= 1'b0;
         line_error  <= 1'b0;
         collision   <= 1'b0;
         err_seen_q  <= 1'b0;
         coll_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= (state_d == StIdle || own_act) ? '0 : idle_cnt_q + 10'd1;
         DI1         <= sel1 & ~both;
         DI0         <= sel0 & ~both;
         line_error  <= both & ~err_seen_q;
         err_seen_q  <= both;
         collision   <= other_act & ~coll_done_q;
         coll_done_q <= (state_d != StIdle) & (coll_done_q | other_act);
         if (state_d == StLockA)      chan_b <= 1'b0;
         else if (state_d == StLockB) chan_b <= 1'b1;
      end
   end

   assign chan_active = (state_q != StIdle);

endmodule

// File: tb/tb_mkio_rx_frontend.sv
// Event scoreboard bench for mkio_rx_frontend: every output change is matched against a
// queue of hand-computed (cycle, output vector) pairs. Vector = {active, chan_b, DI1, DI0, err, coll}.
module tb_mkio_rx_frontend;
   logic clk = 1'b0;
   logic reset_n, DI1A, DI0A, DI1B, DI0B, rx_enable;
   logic DI1, DI0, chan_b, chan_active, line_error, collision;

   mkio_rx_frontend dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .DI1A        (DI1A),
      .DI0A        (DI0A),
      .DI1B        (DI1B),
      .DI0B        (DI0B),
      .rx_enable   (rx_enable),
      .DI1         (DI1),
      .DI0         (DI0),
      .chan_b      (chan_b),
      .chan_active (chan_active),
      .line_error  (line_error),
      .collision   (collision)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } ev_t;

   ev_t        exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;
   logic [5:0] prev_v = '0;
   logic [5:0] cur_v;
   assign cur_v = {chan_active, chan_b, DI1, DI0, line_error, collision};

   function automatic logic [5:0] vec(bit act, bit b, bit d1, bit d0, bit le, bit co);
      return {act, b, d1, d0, le, co};
   endfunction

   function automatic void expect_ev(int c, logic [5:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
   endfunction

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(bit a1, bit a0, bit b1, bit b0);
      DI1A = a1;
      DI0A = a0;
      DI1B = b1;
      DI0B = b0;
   endtask

   // Monitor: pops the scoreboard whenever the outputs change.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missed_event: outputs %b at cycle %0d, required %b at cycle %0d",
                        cur_v, cyc, e.v, e.cyc);
            end
            if (cur_v !== prev_v) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_event: outputs %b at cycle %0d, required unchanged %b",
                           cur_v, cyc, prev_v);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.v !== cur_v) begin
                     n_fail++;
                     $display("FAIL output_event: got %b at cycle %0d, required %b at cycle %0d",
                              cur_v, cyc, e.v, e.cyc);
                  end
               end
               prev_v = cur_v;
            end
         end
      end
   end

   initial begin
      int  t;
      bit  b_en;
`ifdef MKIO_RX_CHAN_B_EN
      b_en = 1'b1;
`else
      b_en = 1'b0;
`endif
      reset_n   = 1'b0;
      rx_enable = 1'b1;
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (cur_v !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, required 000000", cur_v);
      end
      step(1);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // A sends 1-0-1 half-bits of 16 cycles, then silence and timeout.
      step(5);
      t = cyc;
      drive(1, 0, 0, 0);
      expect_ev(t + 6,   vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 22,  vec(1, 0, 0, 1, 0, 0));
      expect_ev(t + 38,  vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 54,  vec(1, 0, 0, 0, 0, 0));
      expect_ev(t + 181, vec(0, 0, 0, 0, 0, 0));
      step(16); drive(0, 1, 0, 0);
      step(16); drive(1, 0, 0, 0);
      step(16); drive(0, 0, 0, 0);
      step(150);

      // Two-cycle glitch on DI1B while idle: nothing may change.
      step(5);
      drive(0, 0, 1, 0);
      step(2);
      drive(0, 0, 0, 0);
      step(20);

      // DI1A and DI1B rise together: A wins, collision once (B build only).
      t = cyc;
      drive(1, 0, 1, 0);
      expect_ev(t + 6, vec(1, 0, 1, 0, 0, b_en));
      if (b_en) expect_ev(t + 7, vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 16,  vec(1, 0, 0, 0, 0, 0));
      expect_ev(t + 143, vec(0, 0, 0, 0, 0, 0));
      step(10); drive(0, 0, 0, 0);
      step(150);

      // Both A lines high for 5 cycles: one line_error, DI forced low for that span.
      t = cyc;
      drive(1, 0, 0, 0);
      expect_ev(t + 6,   vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 14,  vec(1, 0, 0, 0, 1, 0));
      expect_ev(t + 15,  vec(1, 0, 0, 0, 0, 0));
      expect_ev(t + 19,  vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 27,  vec(1, 0, 0, 0, 0, 0));
      expect_ev(t + 154, vec(0, 0, 0, 0, 0, 0));
      step(8); drive(1, 1, 0, 0);
      step(5); drive(1, 0, 0, 0);
      step(8); drive(0, 0, 0, 0);
      step(150);

      // rx_enable dropped mid-word forces idle; no relock once lines are quiet.
      t = cyc;
      drive(1, 0, 0, 0);
      expect_ev(t + 6,  vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 11, vec(0, 0, 0, 0, 0, 0));
      step(10); rx_enable = 1'b0;
      step(4);  drive(0, 0, 0, 0);
      step(6);  rx_enable = 1'b1;
      step(20);

      // B-only word: locks B (chan_b held after timeout) or, A-only build, nothing.
      t = cyc;
      drive(0, 0, 1, 0);
      if (b_en) begin
         expect_ev(t + 6,   vec(1, 1, 1, 0, 0, 0));
         expect_ev(t + 22,  vec(1, 1, 0, 1, 0, 0));
         expect_ev(t + 38,  vec(1, 1, 0, 0, 0, 0));
         expect_ev(t + 165, vec(0, 1, 0, 0, 0, 0));
      end
      step(16); drive(0, 0, 0, 1);
      step(16); drive(0, 0, 0, 0);
      step(150);

      // Reset pulsed mid-word: outputs clear at once, relock needs the full pipeline again.
      t = cyc;
      drive(1, 0, 0, 0);
      expect_ev(t + 6,   vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 10,  vec(0, 0, 0, 0, 0, 0));
      expect_ev(t + 18,  vec(1, 0, 1, 0, 0, 0));
      expect_ev(t + 26,  vec(1, 0, 0, 0, 0, 0));
      expect_ev(t + 153, vec(0, 0, 0, 0, 0, 0));
      step(10); reset_n = 1'b0;
      step(2);  reset_n = 1'b1;
      step(8);  drive(0, 0, 0, 0);
      step(150);

      step(5);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
